uart_tx_msg_scheduler: RTL

Sequences multi-source response traffic into the UART transmit path. Two requesters share one byte-wide write port of the TX FIFO that feeds the UART transmitter:
- register-file read data: 1 byte per message
- ALU result: 2 bytes per message

The block captures each request, arbitrates round-robin, splits the ALU result into bytes, and throttles on FIFO_FULL. It sits between the system controller datapath and the TX FIFO write side, in the same clock domain as the register file and ALU.

---
 rtl/uart_sched_pkg.sv | 23 ++
 rtl/uart_tx_msg_scheduler_if.sv | 26 ++
 rtl/rr_arbiter2.sv | 39 +++
 rtl/uart_tx_msg_scheduler.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/uart_sched_pkg.sv
// Shared constants for the UART TX message scheduler: source indices, default widths, FSM states.
// The SEND_CHK state exists only when TX_CHECKSUM_EN is defined.
package uart_sched_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ALU_WIDTH  = 2 * DEFAULT_DATA_WIDTH;

  localparam int SRC_RF  = 0;
  localparam int SRC_ALU = 1;

  // Three bits leave room for illegal encodings, which the FSM folds back to IDLE.
  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_SEND_RF     = 3'd1,
    ST_SEND_ALU_LO = 3'd2,
    ST_SEND_ALU_HI = 3'd3
`ifdef TX_CHECKSUM_EN
    ,
    ST_SEND_CHK    = 3'd4
`endif
  } sched_state_t;

endpackage

// File: rtl/uart_tx_msg_scheduler_if.sv
// Request/FIFO-write bundle of the UART TX message scheduler.
// master = scheduler side, slave = requesters plus TX FIFO write side.
interface uart_tx_msg_scheduler_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ALU_WIDTH  = 16
);
  logic [DATA_WIDTH-1:0] RF_RD_DATA;
  logic                  RF_RD_VALID;
  logic [ALU_WIDTH-1:0]  ALU_OUT;
  logic                  ALU_OUT_VALID;
  logic                  FIFO_FULL;
  logic [DATA_WIDTH-1:0] WR_DATA;
  logic                  WR_INC;
  logic                  BUSY;
  logic [1:0]            OVR_ERR;

  modport master (
    input  RF_RD_DATA, RF_RD_VALID, ALU_OUT, ALU_OUT_VALID, FIFO_FULL,
    output WR_DATA, WR_INC, BUSY, OVR_ERR
  );

  modport slave (
    output RF_RD_DATA, RF_RD_VALID, ALU_OUT, ALU_OUT_VALID, FIFO_FULL,
    input  WR_DATA, WR_INC, BUSY, OVR_ERR
  );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-request round-robin arbiter. On contention the source opposite last_grant wins;
// last_grant only moves when the accept strobe is pulsed.
module rr_arbiter2
  import uart_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  logic last_grant_q;
  logic last_grant_d;

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = (last_grant_q == 1'(SRC_RF)) ? 2'b10 : 2'b01;
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (accept) begin
      last_grant_d = grant[SRC_ALU];
    end
  end

  // Reset to ALU so RF wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'(SRC_ALU);
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/uart_tx_msg_scheduler.sv
// Merges 1-byte RF reads and 2-byte ALU results into the TX FIFO write port, round-robin,
// throttled by FIFO_FULL. Define TX_CHECKSUM_EN to append an XOR checksum byte per message.
module uart_tx_msg_scheduler
  import uart_sched_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ALU_WIDTH  = 2 * DATA_WIDTH
) (
  input  logic                       CLK,
  input  logic                       RST,
  uart_tx_msg_scheduler_if.master    bus
);

  sched_state_t          state_q, state_d;
  logic [DATA_WIDTH-1:0] rf_buf_q, rf_buf_d;
  logic [ALU_WIDTH-1:0]  alu_buf_q, alu_buf_d;
  logic                  rf_pend_q, rf_pend_d;
  logic                  alu_pend_q, alu_pend_d;
  logic [1:0]            ovr_q, ovr_d;
`ifdef TX_CHECKSUM_EN
  logic                  cur_src_q, cur_src_d;
`endif

  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_inc;
  logic                  busy;
  logic                  rf_last;
  logic                  alu_last;
  logic                  accept;
  logic [1:0]            grant;

`ifdef TX_CHECKSUM_EN
  function automatic logic [DATA_WIDTH-1:0] alu_checksum(input logic [ALU_WIDTH-1:0] w);
    return w[DATA_WIDTH-1:0] ^ w[ALU_WIDTH-1:DATA_WIDTH];
  endfunction
`endif

  rr_arbiter2 u_arb (
    .clk    (CLK),
    .rst_n  (RST),
    .req    ({alu_pend_q, rf_pend_q}),
    .accept (accept),
    .grant  (grant)
  );

  // Sequencer: byte mux, write strobe and end-of-message detection.
  always_comb begin
    state_d  = state_q;
    wr_inc   = 1'b0;
    wr_data  = '0;
    busy     = 1'b0;
    rf_last  = 1'b0;
    alu_last = 1'b0;
    accept   = 1'b0;
`ifdef TX_CHECKSUM_EN
    cur_src_d = cur_src_q;
`endif
    case (state_q)
      ST_IDLE: begin
        accept = rf_pend_q & alu_pend_q;
        if (grant[SRC_RF]) begin
          state_d = ST_SEND_RF;
`ifdef TX_CHECKSUM_EN
          cur_src_d = 1'(SRC_RF);
`endif
        end else if (grant[SRC_ALU]) begin
          state_d = ST_SEND_ALU_LO;
`ifdef TX_CHECKSUM_EN
          cur_src_d = 1'(SRC_ALU);
`endif
        end
      end
      ST_SEND_RF: begin
        busy    = 1'b1;
        wr_inc  = !bus.FIFO_FULL;
        wr_data = rf_buf_q;
        if (wr_inc) begin
`ifdef TX_CHECKSUM_EN
          state_d = ST_SEND_CHK;
`else
          state_d = ST_IDLE;
          rf_last = 1'b1;
`endif
        end
      end
      ST_SEND_ALU_LO: begin
        busy    = 1'b1;
        wr_inc  = !bus.FIFO_FULL;
        wr_data = alu_buf_q[DATA_WIDTH-1:0];
        if (wr_inc) begin
          state_d = ST_SEND_ALU_HI;
        end
      end
      ST_SEND_ALU_HI: begin
        busy    = 1'b1;
        wr_inc  = !bus.FIFO_FULL;
        wr_data = alu_buf_q[ALU_WIDTH-1:DATA_WIDTH];
        if (wr_inc) begin
`ifdef TX_CHECKSUM_EN
          state_d = ST_SEND_CHK;
`else
          state_d  = ST_IDLE;
          alu_last = 1'b1;
`endif
        end
      end
`ifdef TX_CHECKSUM_EN
      ST_SEND_CHK: begin
        busy    = 1'b1;
        wr_inc  = !bus.FIFO_FULL;
        wr_data = (cur_src_q == 1'(SRC_RF)) ? rf_buf_q : alu_checksum(alu_buf_q);
        if (wr_inc) begin
          state_d  = ST_IDLE;
          rf_last  = (cur_src_q == 1'(SRC_RF));
          alu_last = (cur_src_q == 1'(SRC_ALU));
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Capture: a pulse that lands on its own message's final write is accepted, not dropped.
  always_comb begin
    rf_buf_d   = rf_buf_q;
    rf_pend_d  = rf_pend_q;
    alu_buf_d  = alu_buf_q;
    alu_pend_d = alu_pend_q;
    ovr_d      = '0;
    if (bus.RF_RD_VALID) begin
      if (rf_pend_q && !rf_last) begin
        ovr_d[SRC_RF] = 1'b1;
      end else begin
        rf_buf_d  = bus.RF_RD_DATA;
        rf_pend_d = 1'b1;
      end
    end else if (rf_last) begin
      rf_pend_d = 1'b0;
    end
    if (bus.ALU_OUT_VALID) begin
      if (alu_pend_q && !alu_last) begin
        ovr_d[SRC_ALU] = 1'b1;
      end else begin
        alu_buf_d  = bus.ALU_OUT;
        alu_pend_d = 1'b1;
      end
    end else if (alu_last) begin
      alu_pend_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= ST_IDLE;
      rf_buf_q   <= '0;
      alu_buf_q  <= '0;
      rf_pend_q  <= 1'b0;
      alu_pend_q <= 1'b0;
      ovr_q      <= '0;
`ifdef TX_CHECKSUM_EN
      cur_src_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rf_buf_q   <= rf_buf_d;
      alu_buf_q  <= alu_buf_d;
      rf_pend_q  <= rf_pend_d;
      alu_pend_q <= alu_pend_d;
      ovr_q      <= ovr_d;
`ifdef TX_CHECKSUM_EN
      cur_src_q  <= cur_src_d;
`endif
    end
  end

  assign bus.WR_DATA = wr_data;
  assign bus.WR_INC  = wr_inc;
  assign bus.BUSY    = busy;
  assign bus.OVR_ERR = ovr_q;

endmodule
